// File: rtl/polar_pkg.sv
// Shared types and helpers for the polar FM discriminator.
package polar_pkg;

  // Squelch gate states
  typedef enum logic [1:0] {
    SQ_MUTED = 2'd0,
    SQ_OPEN  = 2'd1,
    SQ_HANG  = 2'd2
  } sq_state_t;

  // Full phase word width: two quadrant bits on top of the in-quadrant angle
  function automatic int phase_w(input int aw);
    return aw + 2;
  endfunction

endpackage

// File: rtl/boxcar_avg.sv
// Running boxcar average over 2**LOG2 samples: shift register of past inputs
// plus an accumulator that adds the newest sample and drops the oldest.
module boxcar_avg
  import polar_pkg::*;
#(
  parameter int W    = 18,
  parameter int LOG2 = 2
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic                valid_i,
  input  logic                clr_i,
  input  logic signed [W-1:0] d_i,
  output logic signed [W-1:0] q_o
);

  localparam int DEPTH = 1 << LOG2;
  localparam int ACW   = W + LOG2;

  logic signed [W-1:0]   hist [DEPTH];
  logic signed [ACW-1:0] acc;
  logic signed [ACW-1:0] d_ext;
  logic signed [ACW-1:0] old_ext;

  assign d_ext   = ACW'(d_i);
  assign old_ext = ACW'(hist[DEPTH-1]);

  // Push new sample, retire oldest; a clear wipes history and sum together
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      acc <= '0;
      for (int i = 0; i < DEPTH; i++) hist[i] <= '0;
    end else if (valid_i) begin
      if (clr_i) begin
        acc <= '0;
        for (int i = 0; i < DEPTH; i++) hist[i] <= '0;
      end else begin
        acc     <= acc + d_ext - old_ext;
        hist[0] <= d_i;
        for (int i = 1; i < DEPTH; i++) hist[i] <= hist[i-1];
      end
    end
  end

  // Floor division by the window length via arithmetic shift
  assign q_o = W'(acc >>> LOG2);

endmodule

// File: rtl/polar_fm_discriminator.sv
// Polar FM discriminator: wrapped phase difference per sample, gated by a
// magnitude squelch with hysteresis and hang time, then boxcar smoothed.
// Fixed 2-clock latency from valid_i to valid_o.
module polar_fm_discriminator #(
  parameter int DW       = 16,
  parameter int AW       = 16,
  parameter int AVG_LOG2 = 2,
  parameter int SQ_OPEN  = 512,
  parameter int SQ_CLOSE = 256,
  parameter int HANG_LEN = 4
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 valid_i,
  input  logic [DW-1:0]        r_i,
  input  logic [AW-1:0]        angle_i,
  input  logic [1:0]           quadrant_i,
  output logic signed [AW+1:0] freq_o,
  output logic                 open_o,
  output logic                 valid_o
);

  import polar_pkg::sq_state_t;
  import polar_pkg::SQ_MUTED;
  import polar_pkg::SQ_HANG;
  import polar_pkg::phase_w;

  localparam int PW  = phase_w(AW);
  localparam int HCW = (HANG_LEN < 1) ? 1 : $clog2(HANG_LEN + 1);

  sq_state_t        state, nxt_state;
  logic [HCW-1:0]   hang_cnt, nxt_cnt;
  logic [PW-1:0]    phase, prev_phase, raw_diff;
  logic             prev_valid;
  logic signed [PW-1:0] delta;

  logic                 s1_valid, s1_open, s1_clr;
  logic signed [PW-1:0] s1_delta;
  logic                 s2_valid, s2_open;
  logic signed [PW-1:0] avg_q;

  assign phase    = {quadrant_i, angle_i};
  assign raw_diff = phase - prev_phase;
  assign delta    = prev_valid ? $signed(raw_diff) : '0;

  // Squelch next-state from the current sample's magnitude
  always_comb begin
    nxt_state = state;
    nxt_cnt   = hang_cnt;
    case (state)
      SQ_MUTED: begin
        if (r_i >= DW'(SQ_OPEN)) nxt_state = polar_pkg::SQ_OPEN;
      end
      polar_pkg::SQ_OPEN: begin
        if (r_i < DW'(SQ_CLOSE)) begin
          nxt_state = SQ_HANG;
          nxt_cnt   = HCW'(1);
        end
      end
      SQ_HANG: begin
        if (r_i >= DW'(SQ_CLOSE)) nxt_state = polar_pkg::SQ_OPEN;
        else if (hang_cnt == HCW'(HANG_LEN)) nxt_state = SQ_MUTED;
        else nxt_cnt = hang_cnt + HCW'(1);
      end
      default: nxt_state = SQ_MUTED;
    endcase
  end

  // Stage 1: phase history, squelch state, and the gated difference
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state      <= SQ_MUTED;
      hang_cnt   <= '0;
      prev_phase <= '0;
      prev_valid <= 1'b0;
      s1_valid   <= 1'b0;
      s1_open    <= 1'b0;
      s1_clr     <= 1'b0;
      s1_delta   <= '0;
    end else begin
      s1_valid <= valid_i;
      if (valid_i) begin
        state      <= nxt_state;
        hang_cnt   <= nxt_cnt;
        prev_phase <= phase;
        prev_valid <= 1'b1;
        s1_open    <= (nxt_state != SQ_MUTED);
        s1_clr     <= (nxt_state == SQ_MUTED) && (state != SQ_MUTED);
        s1_delta   <= (nxt_state != SQ_MUTED) ? delta : '0;
      end
    end
  end

  boxcar_avg #(
    .W    (PW),
    .LOG2 (AVG_LOG2)
  ) u_avg (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .valid_i (s1_valid),
    .clr_i   (s1_clr),
    .d_i     (s1_delta),
    .q_o     (avg_q)
  );

  // Stage 2: carry the open flag alongside the averager update
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      s2_valid <= 1'b0;
      s2_open  <= 1'b0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) s2_open <= s1_open;
    end
  end

  // Output registers hold their value between samples
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      valid_o <= 1'b0;
      open_o  <= 1'b0;
      freq_o  <= '0;
    end else begin
      valid_o <= s2_valid;
      if (s2_valid) begin
        open_o <= s2_open;
        freq_o <= avg_q;
      end
    end
  end

endmodule

// File: tb/tb_polar_fm_discriminator.sv
// Directed bench for polar_fm_discriminator: two instances (4-sample average
// and no average) share one stimulus stream; outputs are collected per
// valid_o and compared against hand-computed tables.
module tb_polar_fm_discriminator;

  logic        clk;
  logic        rstn;
  logic        valid_in;
  logic [15:0] r_val;
  logic [15:0] angle;
  logic [1:0]  quad;

  logic signed [17:0] freq_a, freq_b;
  logic               open_a, open_b, valid_a, valid_b;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int   r;
    int   ph;
    int   freq;
    logic open;
  } vec_t;

  vec_t vecs[$];
  int   q_fa[$], q_oa[$], q_fb[$], q_ob[$];

  polar_fm_discriminator #(
    .DW(16), .AW(16), .AVG_LOG2(2), .SQ_OPEN(512), .SQ_CLOSE(256), .HANG_LEN(4)
  ) dut_avg (
    .clk_i(clk), .rstn_i(rstn), .valid_i(valid_in), .r_i(r_val),
    .angle_i(angle), .quadrant_i(quad),
    .freq_o(freq_a), .open_o(open_a), .valid_o(valid_a)
  );

  polar_fm_discriminator #(
    .DW(16), .AW(16), .AVG_LOG2(0), .SQ_OPEN(512), .SQ_CLOSE(256), .HANG_LEN(4)
  ) dut_raw (
    .clk_i(clk), .rstn_i(rstn), .valid_i(valid_in), .r_i(r_val),
    .angle_i(angle), .quadrant_i(quad),
    .freq_o(freq_b), .open_o(open_b), .valid_o(valid_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Collect every output sample away from the active edge
  always @(negedge clk) begin
    if (valid_a) begin
      q_fa.push_back(int'(freq_a));
      q_oa.push_back(int'(open_a));
    end
    if (valid_b) begin
      q_fb.push_back(int'(freq_b));
      q_ob.push_back(int'(open_b));
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Drive one sample for one clock; called at a negedge, returns at the next
  task automatic applyStimulus(input int r, input int ph);
    logic [31:0] p;
    p        = ph;
    valid_in = 1'b1;
    r_val    = r[15:0];
    angle    = p[15:0];
    quad     = p[17:16];
    @(negedge clk);
    valid_in = 1'b0;
  endtask

  task automatic doReset();
    rstn     = 1'b0;
    valid_in = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic addVec(input int r, input int ph, input int freq, input logic open);
    vec_t v;
    v.r = r; v.ph = ph; v.freq = freq; v.open = open;
    vecs.push_back(v);
  endtask

  // Apply the table with 'gap' idle clocks between samples and compare
  task automatic runVectors(input string name, input int use_raw, input int gap);
    int sz;
    int act_f, act_o;
    q_fa.delete(); q_oa.delete(); q_fb.delete(); q_ob.delete();
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].r, vecs[i].ph);
      repeat (gap) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    sz = use_raw ? q_fb.size() : q_fa.size();
    checkOutput($sformatf("%s count", name), sz, vecs.size());
    foreach (vecs[i]) begin
      act_f = 32'h7fff_ffff;
      act_o = -1;
      if (i < sz) begin
        act_f = use_raw ? q_fb[i] : q_fa[i];
        act_o = use_raw ? q_ob[i] : q_oa[i];
      end
      checkOutput($sformatf("%s freq[%0d]", name, i), act_f, vecs[i].freq);
      checkOutput($sformatf("%s open[%0d]", name, i), act_o, int'(vecs[i].open));
    end
  endtask

  task automatic loadBurstTable();
    vecs.delete();
    addVec(300,    1000,    0, 1'b0);
    addVec(700,    3000,  500, 1'b1);
    addVec(700,    2000,  250, 1'b1);
    addVec(700, 262128, -254, 1'b1);
    addVec(700,      16, -246, 1'b1);
    addVec(700,      16, -746, 1'b1);
  endtask

  initial begin
    rstn     = 1'b0;
    valid_in = 1'b0;
    r_val    = '0;
    angle    = '0;
    quad     = '0;

    // Reset state
    @(negedge clk);
    checkOutput("reset freq", int'(freq_a), 0);
    checkOutput("reset open", int'(open_a), 0);
    checkOutput("reset valid", int'(valid_a), 0);
    doReset();

    // Constant rotation, +4096 per sample
    vecs.delete();
    addVec(1000,     0,    0, 1'b1);
    addVec(1000,  4096, 1024, 1'b1);
    addVec(1000,  8192, 2048, 1'b1);
    addVec(1000, 12288, 3072, 1'b1);
    for (int k = 4; k < 8; k++) addVec(1000, k * 4096, 4096, 1'b1);
    runVectors("rotation", 0, 0);

    // Latency and hold after a single sample
    applyStimulus(1000, 8 * 4096);
    checkOutput("latency valid +1", int'(valid_a), 0);
    @(negedge clk);
    checkOutput("latency valid +2 pre", int'(valid_a), 0);
    @(negedge clk);
    checkOutput("latency valid +2", int'(valid_a), 1);
    checkOutput("latency freq", int'(freq_a), 4096);
    @(negedge clk);
    checkOutput("pulse width", int'(valid_a), 0);
    repeat (3) @(negedge clk);
    checkOutput("hold freq", int'(freq_a), 4096);
    checkOutput("hold open", int'(open_a), 1);

    // Wrap and half circle without averaging
    doReset();
    vecs.delete();
    addVec(1000, 32'h3FF00,       0, 1'b1);
    addVec(1000, 32'h00100,     512, 1'b1);
    addVec(1000,         0,    -256, 1'b1);
    addVec(1000, 32'h20000, -131072, 1'b1);
    addVec(1000,         0, -131072, 1'b1);
    addVec(1000, 32'h1FFFF,  131071, 1'b1);
    runVectors("wrap", 1, 0);

    // Squelch close through hang, stay muted below open threshold, reopen
    doReset();
    vecs.delete();
    addVec(1000,     0,    0, 1'b1);
    addVec(1000,  4096, 1024, 1'b1);
    addVec(1000,  8192, 2048, 1'b1);
    addVec(1000, 12288, 3072, 1'b1);
    addVec(1000, 16384, 4096, 1'b1);
    for (int k = 5; k < 9; k++) addVec(100, k * 4096, 4096, 1'b1);
    addVec(100, 9 * 4096, 0, 1'b0);
    addVec(400, 10 * 4096, 0, 1'b0);
    addVec(400, 11 * 4096, 0, 1'b0);
    addVec(600, 46056,  250, 1'b1);
    addVec(600, 45053,   -1, 1'b1);
    addVec(600, 45053,   -1, 1'b1);
    addVec(600, 45060,    1, 1'b1);
    addVec(600, 45060, -249, 1'b1);
    runVectors("squelch", 0, 0);

    // Hang recovery back to open, then a fresh full hang period
    doReset();
    vecs.delete();
    addVec(1000,     0,    0, 1'b1);
    addVec(100,   4096, 1024, 1'b1);
    addVec(100,   8192, 2048, 1'b1);
    addVec(300,  12288, 3072, 1'b1);
    for (int k = 4; k < 8; k++) addVec(100, k * 4096, 4096, 1'b1);
    addVec(100, 8 * 4096, 0, 1'b0);
    runVectors("hang", 0, 0);

    // Asynchronous reset in the middle of a burst
    doReset();
    applyStimulus(1000, 0);
    applyStimulus(1000, 4096);
    applyStimulus(1000, 8192);
    @(posedge clk);
    #2;
    checkOutput("pre-reset freq", int'(freq_a), 1024);
    rstn = 1'b0;
    #1;
    checkOutput("async reset freq", int'(freq_a), 0);
    checkOutput("async reset open", int'(open_a), 0);
    checkOutput("async reset valid", int'(valid_a), 0);
    q_fa.delete(); q_oa.delete(); q_fb.delete(); q_ob.delete();
    @(negedge clk);
    rstn = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("dropped in-flight", q_fa.size(), 0);

    // Same burst back-to-back and gapped (one sample every 4 clocks)
    loadBurstTable();
    runVectors("burst b2b", 0, 0);
    doReset();
    loadBurstTable();
    runVectors("burst gapped", 0, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
